regbank_arbiter: RTL and testbench

Shares a single WIDTH-bit D-flip-flop register bank between NREQ requesters. It arbitrates requests, grants one requester at a time, and applies that requester's operation (load, preset, clear, toggle) to the bank. The bank outputs `q`/`qb` feed the downstream datapath. The block is the sequencer that owns every write to the bank, so no requester drives the flops directly.

---
 rtl/regbank_arbiter.sv | 165 ++++++++++++++++
 tb/tb_regbank_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_arbiter.sv
// regbank_arbiter: arbitrates NREQ requesters for exclusive write access to a
// WIDTH-bit register bank. Each granted requester gets one operation
// (load, preset, clear, toggle) applied to the bank.
// Optional feature macro: REGARB_RR_EN selects round-robin arbitration;
// when it is undefined, fixed priority (lowest index wins) is used.
module regbank_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [2*NREQ-1:0]       op,
   input  logic [NREQ*WIDTH-1:0]   din,
   output logic [NREQ-1:0]         gnt,
   output logic                    done,
   output logic                    busy,
   output logic [WIDTH-1:0]        q,
   output logic [WIDTH-1:0]        qb
);

   localparam int SELW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GRANT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [1:0] OP_LOAD   = 2'b00;
   localparam logic [1:0] OP_PRESET = 2'b01;
   localparam logic [1:0] OP_CLEAR  = 2'b10;

   logic [1:0]        state_q, state_d;
   logic [SELW-1:0]   sel_q, sel_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic [WIDTH-1:0]  bank_q, bank_d;

   logic [SELW-1:0]   winner;
   logic              found;
   logic [1:0]        opSel;
   logic [WIDTH-1:0]  dinSel;

`ifdef REGARB_RR_EN
   logic [SELW-1:0]   ptr_q, ptr_d;
   int                searchIdx;

   // Round-robin search: start at the pointer, wrap around, first active request wins
   always_comb begin
      winner    = '0;
      found     = 1'b0;
      searchIdx = 0;
      for (int k = 0; k < NREQ; k++) begin
         searchIdx = (int'(ptr_q) + k) % NREQ;
         if (!found && req[searchIdx]) begin
            found  = 1'b1;
            winner = SELW'(searchIdx);
         end
      end
   end
`else
   // Fixed priority search: scanning downward leaves the lowest active index as winner
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[k]) begin
            found  = 1'b1;
            winner = SELW'(k);
         end
      end
   end
`endif

   // Pick out the latched requester's opcode and load data for the GRANT cycle
   always_comb begin
      opSel  = op[2*int'(sel_q) +: 2];
      dinSel = din[WIDTH*int'(sel_q) +: WIDTH];
   end

   // Sequencer next-state logic: IDLE -> GRANT -> DONE -> IDLE, bank written only in GRANT
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      bank_d  = bank_q;
`ifdef REGARB_RR_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               sel_d   = winner;
               state_d = GRANT;
               gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << winner;
               busy_d  = 1'b1;
            end else begin
               gnt_d   = '0;
               busy_d  = 1'b0;
            end
         end
         GRANT: begin
            case (opSel)
               OP_LOAD:   bank_d = dinSel;
               OP_PRESET: bank_d = '1;
               OP_CLEAR:  bank_d = '0;
               default:   bank_d = ~bank_q;
            endcase
            state_d = DONE;
            done_d  = 1'b1;
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
`ifdef REGARB_RR_EN
            if (int'(sel_q) == NREQ - 1) begin
               ptr_d = '0;
            end else begin
               ptr_d = sel_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; synchronous reset aborts any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         gnt_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         bank_q  <= '0;
`ifdef REGARB_RR_EN
         ptr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         bank_q  <= bank_d;
`ifdef REGARB_RR_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   assign gnt  = gnt_q;
   assign done = done_q;
   assign busy = busy_q;
   assign q    = bank_q;
   assign qb   = ~bank_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Testbench for regbank_arbiter: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a transaction-level
// model of the arbiter. Honours REGARB_RR_EN the same way the design does.
module tb_regbank_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [2*NREQ-1:0]     op;
   logic [NREQ*WIDTH-1:0] din;
   logic [NREQ-1:0]       gnt;
   logic                  done;
   logic                  busy;
   logic [WIDTH-1:0]      q;
   logic [WIDTH-1:0]      qb;

   int nChecks = 0;
   int nPass   = 0;
   bit checkEn = 1'b0;

   // Model: phase 0 = no operation, 1 = requester granted, 2 = operation completed
   int               mPhase = 0;
   int               mSel   = 0;
   int               mPtr   = 0;
   logic [WIDTH-1:0] mQ     = '0;

   regbank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .op   (op),
      .din  (din),
      .gnt  (gnt),
      .done (done),
      .busy (busy),
      .q    (q),
      .qb   (qb)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // Winner by the arbitration rule: first requester at or after 'start', wrapping
   function automatic int pickWinner(input logic [NREQ-1:0] r, input int start);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(start + k) % NREQ]) return (start + k) % NREQ;
      end
      return 0;
   endfunction

   // Effect of one opcode on the bank contents
   function automatic logic [WIDTH-1:0] applyOp(input logic [1:0] opc,
                                                input logic [WIDTH-1:0] data,
                                                input logic [WIDTH-1:0] cur);
      case (opc)
         2'b00:   return data;
         2'b01:   return {WIDTH{1'b1}};
         2'b10:   return {WIDTH{1'b0}};
         default: return ~cur;
      endcase
   endfunction

   // Reference model advances one operation phase per rising edge
   always @(posedge clk) begin
      if (rst) begin
         mPhase <= 0;
         mSel   <= 0;
         mPtr   <= 0;
         mQ     <= '0;
      end else begin
         case (mPhase)
            0: begin
               if (req != '0) begin
`ifdef REGARB_RR_EN
                  mSel <= pickWinner(req, mPtr);
`else
                  mSel <= pickWinner(req, 0);
`endif
                  mPhase <= 1;
               end
            end
            1: begin
               mQ     <= applyOp(op[2*mSel +: 2], din[WIDTH*mSel +: WIDTH], mQ);
               mPhase <= 2;
            end
            default: begin
               mPhase <= 0;
               mPtr   <= (mSel + 1) % NREQ;
            end
         endcase
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) begin
         nPass++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of all outputs against the model, away from the active edge
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("model gnt",  {28'd0, gnt},  (mPhase != 0) ? (32'd1 << mSel) : 32'd0);
         checkOutput("model done", {31'd0, done}, {31'd0, (mPhase == 2)});
         checkOutput("model busy", {31'd0, busy}, {31'd0, (mPhase != 0)});
         checkOutput("model q",    {24'd0, q},    {24'd0, mQ});
         checkOutput("model qb",   {24'd0, qb},   {24'd0, ~mQ});
      end
   end

   // Present one operation from a single requester and check its literal outcome
   task automatic applyStimulus(input int idx, input logic [1:0] opc,
                                input logic [WIDTH-1:0] data, input logic [WIDTH-1:0] expQ,
                                input string name);
      req = '0;
      req[idx] = 1'b1;
      op[2*idx +: 2] = opc;
      din[WIDTH*idx +: WIDTH] = data;
      @(negedge clk);
      checkOutput({name, " gnt"}, {28'd0, gnt}, 32'd1 << idx);
      @(negedge clk);
      checkOutput({name, " q"},    {24'd0, q},  {24'd0, expQ});
      checkOutput({name, " qb"},   {24'd0, qb}, {24'd0, ~expQ});
      checkOutput({name, " done"}, {31'd0, done}, 32'd1);
      req = '0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      op  = '0;
      din = '0;
      @(negedge clk);
      checkEn = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("reset q",    {24'd0, q},    32'h00);
      checkOutput("reset qb",   {24'd0, qb},   32'hFF);
      checkOutput("reset gnt",  {28'd0, gnt},  32'h0);
      checkOutput("reset busy", {31'd0, busy}, 32'h0);
      @(negedge clk);

      // Single load from requester 2
      applyStimulus(2, 2'b00, 8'hA5, 8'hA5, "load2");

      // Preset, clear, load, toggle from requester 1
      applyStimulus(1, 2'b01, 8'h00, 8'hFF, "preset1");
      applyStimulus(1, 2'b10, 8'h00, 8'h00, "clear1");
      applyStimulus(1, 2'b00, 8'h3C, 8'h3C, "load1");
      applyStimulus(1, 2'b11, 8'h3C, 8'hC3, "toggle1");

      // Reset held two cycles while requester 3 is granted a preset
      req = 4'b1000;
      op[7:6] = 2'b01;
      @(negedge clk);
      checkOutput("rstmid gnt before", {28'd0, gnt}, 32'h8);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checkOutput("rstmid q",    {24'd0, q},    32'h00);
         checkOutput("rstmid qb",   {24'd0, qb},   32'hFF);
         checkOutput("rstmid gnt",  {28'd0, gnt},  32'h0);
         checkOutput("rstmid done", {31'd0, done}, 32'h0);
      end
      rst = 1'b0;
      req = '0;
      @(negedge clk);
      checkOutput("rstmid done after", {31'd0, done}, 32'h0);
      checkOutput("rstmid q after",    {24'd0, q},    32'h00);

      // Requester 0 drops its request during GRANT; the load still lands
      req = 4'b0001;
      op[1:0] = 2'b00;
      din[7:0] = 8'h5A;
      @(negedge clk);
      checkOutput("drop gnt", {28'd0, gnt}, 32'h1);
      req = '0;
      @(negedge clk);
      checkOutput("drop q",    {24'd0, q},    32'h5A);
      checkOutput("drop done", {31'd0, done}, 32'h1);
      @(negedge clk);

      // Contention with requests held: reset first so the pointer starts at 0
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
`ifdef REGARB_RR_EN
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput("rr gnt", {28'd0, gnt}, 32'd1 << (k % NREQ));
         @(negedge clk);
         @(negedge clk);
      end
`else
      req = 4'b1010;
      op[3:2] = 2'b11;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("prio gnt", {28'd0, gnt}, 32'h2);
         @(negedge clk);
         @(negedge clk);
      end
`endif
      req = '0;
      @(negedge clk);
      @(negedge clk);

      // Randomized traffic, including rare resets and requests that change at any time
      for (int c = 0; c < 800; c++) begin
         rst = ($urandom_range(0, 49) == 0);
         req = NREQ'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) req = '0;
         op  = (2*NREQ)'($urandom);
         din = (NREQ*WIDTH)'($urandom);
         @(negedge clk);
      end

      rst = 1'b0;
      req = '0;
      repeat (4) @(negedge clk);
      checkEn = 1'b0;
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
